// File: rtl/or1300_pkg.sv
// Shared definitions for the OR1300 logic/extend datapath: register index
// width and the control codes understood by the logic unit.
package or1300_pkg;

    // Register-file index width.
    localparam int unsigned REG_ADDR_WIDTH = 5;

    // Width of the logic/extend control code.
    localparam int unsigned CTRL_WIDTH = 3;

    // Width of the data path.
    localparam int unsigned DATA_WIDTH = 32;

    // Logic/extend unit control codes.
    typedef enum logic [CTRL_WIDTH-1:0] {
        CtrlPass   = 3'b000,
        CtrlAnd    = 3'b001,
        CtrlOr     = 3'b010,
        CtrlXor    = 3'b011,
        CtrlSext16 = 3'b100,
        CtrlSext8  = 3'b101,
        CtrlZext16 = 3'b110,
        CtrlZext8  = 3'b111
    } ctrl_e;

endpackage

// File: rtl/operand_forward.sv
// Per-operand resolution mux for the held instruction in the operand stage.
// Priority: immediate/bypass > index 0 (reads zero) > mem result > wb result
// > held value. Forwarding paths are removed when FORWARD_EN is 0.
module operand_forward
    import or1300_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH_P = or1300_pkg::REG_ADDR_WIDTH,
    parameter bit          FORWARD_EN       = 1'b1
) (
    input  logic [REG_ADDR_WIDTH_P-1:0] i_src,
    input  logic                        i_bypass,
    input  logic [DATA_WIDTH-1:0]       i_held,
    input  logic                        i_mem_we,
    input  logic [REG_ADDR_WIDTH_P-1:0] i_mem_dest,
    input  logic [DATA_WIDTH-1:0]       i_mem_data,
    input  logic                        i_wb_we,
    input  logic [REG_ADDR_WIDTH_P-1:0] i_wb_dest,
    input  logic [DATA_WIDTH-1:0]       i_wb_data,
    output logic [DATA_WIDTH-1:0]       o_operand
);

    logic w_src_zero;
    logic w_mem_hit;
    logic w_wb_hit;

    // Match detection; index 0 is never forwarded.
    always_comb begin
        w_src_zero = (i_src == '0);
        w_mem_hit  = FORWARD_EN && i_mem_we && !w_src_zero && (i_mem_dest == i_src);
        w_wb_hit   = FORWARD_EN && i_wb_we  && !w_src_zero && (i_wb_dest  == i_src);
    end

    // Priority select of the resolved operand value.
    always_comb begin
        o_operand = i_held;
        if (i_bypass) begin
            o_operand = i_held;
        end else if (w_src_zero) begin
            o_operand = '0;
        end else if (w_mem_hit) begin
            o_operand = i_mem_data;
        end else if (w_wb_hit) begin
            o_operand = i_wb_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage in front of the logic/extend unit: a single-entry pipeline
// register with valid/ready handshakes on both sides.
// Build option: OR1300_OPERAND_FORWARD_EN. When defined, held operands are
// corrected from the mem/wb results and decode never stalls. When undefined,
// no forwarding is done and decode stalls on any pending writer of a used
// source register.
module alu_operand_stage
#(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      nReset,
    // Decode side
    input  logic                      idValid,
    output logic                      idReady,
    input  logic [2:0]                idControl,
    input  logic [REG_ADDR_WIDTH-1:0] idRegA,
    input  logic [REG_ADDR_WIDTH-1:0] idRegB,
    input  logic [31:0]               idRegAData,
    input  logic [31:0]               idRegBData,
    input  logic                      idUseImm,
    input  logic [31:0]               idImmediate,
    input  logic [REG_ADDR_WIDTH-1:0] idDest,
    input  logic                      idWriteEn,
    input  logic                      flush,
    // Downstream results
    input  logic                      memWriteEn,
    input  logic [REG_ADDR_WIDTH-1:0] memDest,
    input  logic [31:0]               memData,
    input  logic                      wbWriteEn,
    input  logic [REG_ADDR_WIDTH-1:0] wbDest,
    input  logic [31:0]               wbData,
    // Execute side
    output logic                      exValid,
    input  logic                      exReady,
    output logic [2:0]                exControl,
    output logic [31:0]               exOperantA,
    output logic [31:0]               exOperantB,
    output logic [REG_ADDR_WIDTH-1:0] exDest,
    output logic                      exWriteEn
);

    import or1300_pkg::*;

`ifdef OR1300_OPERAND_FORWARD_EN
    localparam bit ForwardEn = 1'b1;
`else
    localparam bit ForwardEn = 1'b0;
`endif

    // Held instruction
    logic                      r_valid;
    ctrl_e                     r_control;
    logic [31:0]               r_op_a;
    logic [31:0]               r_op_b;
    logic [REG_ADDR_WIDTH-1:0] r_src_a;
    logic [REG_ADDR_WIDTH-1:0] r_src_b;
    logic                      r_use_imm;
    logic [REG_ADDR_WIDTH-1:0] r_dest;
    logic                      r_write_en;

    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic        w_hazard;
    logic        w_ready_core;
    logic        w_capture;

    operand_forward #(
        .REG_ADDR_WIDTH_P (REG_ADDR_WIDTH),
        .FORWARD_EN       (ForwardEn)
    ) u_fwd_a (
        .i_src      (r_src_a),
        .i_bypass   (1'b0),
        .i_held     (r_op_a),
        .i_mem_we   (memWriteEn),
        .i_mem_dest (memDest),
        .i_mem_data (memData),
        .i_wb_we    (wbWriteEn),
        .i_wb_dest  (wbDest),
        .i_wb_data  (wbData),
        .o_operand  (w_op_a)
    );

    operand_forward #(
        .REG_ADDR_WIDTH_P (REG_ADDR_WIDTH),
        .FORWARD_EN       (ForwardEn)
    ) u_fwd_b (
        .i_src      (r_src_b),
        .i_bypass   (r_use_imm),
        .i_held     (r_op_b),
        .i_mem_we   (memWriteEn),
        .i_mem_dest (memDest),
        .i_mem_data (memData),
        .i_wb_we    (wbWriteEn),
        .i_wb_dest  (wbDest),
        .i_wb_data  (wbData),
        .o_operand  (w_op_b)
    );

`ifdef OR1300_OPERAND_FORWARD_EN
    // Forwarding resolves every dependency, so decode never stalls.
    always_comb begin
        w_hazard = 1'b0;
    end
`else
    logic w_use_a;
    logic w_use_b;
    logic w_hit_a;
    logic w_hit_b;

    // Stall while any in-flight writer targets a used nonzero source.
    always_comb begin
        w_use_a  = (idRegA != '0);
        w_use_b  = !idUseImm && (idRegB != '0);
        w_hit_a  = (r_valid && r_write_en && (r_dest == idRegA))
                || (memWriteEn && (memDest == idRegA))
                || (wbWriteEn && (wbDest == idRegA));
        w_hit_b  = (r_valid && r_write_en && (r_dest == idRegB))
                || (memWriteEn && (memDest == idRegB))
                || (wbWriteEn && (wbDest == idRegB));
        w_hazard = (w_use_a && w_hit_a) || (w_use_b && w_hit_b);
    end
`endif

    // Accept when the slot is empty or draining this cycle, and no hazard.
    always_comb begin
        w_ready_core = (!r_valid || exReady) && !w_hazard;
        w_capture    = idValid && w_ready_core;
        // The slot is empty during reset, so decode is always offered ready.
        idReady      = w_ready_core || !nReset;
    end

    // Pipeline register: flush > capture > drain > hold with operand refresh.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_valid    <= 1'b0;
            r_control  <= CtrlPass;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_src_a    <= '0;
            r_src_b    <= '0;
            r_use_imm  <= 1'b0;
            r_dest     <= '0;
            r_write_en <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid    <= 1'b1;
            r_control  <= ctrl_e'(idControl);
            r_op_a     <= idRegAData;
            r_op_b     <= idUseImm ? idImmediate : idRegBData;
            r_src_a    <= idRegA;
            r_src_b    <= idRegB;
            r_use_imm  <= idUseImm;
            r_dest     <= idDest;
            r_write_en <= idWriteEn;
        end else if (r_valid) begin
            if (exReady) begin
                r_valid <= 1'b0;
            end else begin
                // Latch the resolved values so a forward seen while stalled
                // survives after the producer retires.
                r_op_a <= w_op_a;
                r_op_b <= w_op_b;
            end
        end
    end

    // Execute-side outputs.
    always_comb begin
        exValid    = r_valid;
        exControl  = r_control;
        exOperantA = w_op_a;
        exOperantB = w_op_b;
        exDest     = r_dest;
        exWriteEn  = r_write_en;
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage.
module tb_alu_operand_stage;

    logic        clock;
    logic        nReset;
    logic        idValid;
    logic        idReady;
    logic [2:0]  idControl;
    logic [4:0]  idRegA;
    logic [4:0]  idRegB;
    logic [31:0] idRegAData;
    logic [31:0] idRegBData;
    logic        idUseImm;
    logic [31:0] idImmediate;
    logic [4:0]  idDest;
    logic        idWriteEn;
    logic        flush;
    logic        memWriteEn;
    logic [4:0]  memDest;
    logic [31:0] memData;
    logic        wbWriteEn;
    logic [4:0]  wbDest;
    logic [31:0] wbData;
    logic        exValid;
    logic        exReady;
    logic [2:0]  exControl;
    logic [31:0] exOperantA;
    logic [31:0] exOperantB;
    logic [4:0]  exDest;
    logic        exWriteEn;

    int n_checks;
    int n_errors;

    alu_operand_stage #(
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clock       (clock),
        .nReset      (nReset),
        .idValid     (idValid),
        .idReady     (idReady),
        .idControl   (idControl),
        .idRegA      (idRegA),
        .idRegB      (idRegB),
        .idRegAData  (idRegAData),
        .idRegBData  (idRegBData),
        .idUseImm    (idUseImm),
        .idImmediate (idImmediate),
        .idDest      (idDest),
        .idWriteEn   (idWriteEn),
        .flush       (flush),
        .memWriteEn  (memWriteEn),
        .memDest     (memDest),
        .memData     (memData),
        .wbWriteEn   (wbWriteEn),
        .wbDest      (wbDest),
        .wbData      (wbData),
        .exValid     (exValid),
        .exReady     (exReady),
        .exControl   (exControl),
        .exOperantA  (exOperantA),
        .exOperantB  (exOperantB),
        .exDest      (exDest),
        .exWriteEn   (exWriteEn)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        nReset      = 1'b0;
        idValid     = 1'b0;
        idControl   = 3'b000;
        idRegA      = 5'd0;
        idRegB      = 5'd0;
        idRegAData  = 32'h0;
        idRegBData  = 32'h0;
        idUseImm    = 1'b0;
        idImmediate = 32'h0;
        idDest      = 5'd0;
        idWriteEn   = 1'b0;
        flush       = 1'b0;
        memWriteEn  = 1'b0;
        memDest     = 5'd0;
        memData     = 32'h0;
        wbWriteEn   = 1'b0;
        wbDest      = 5'd0;
        wbData      = 32'h0;
        exReady     = 1'b0;

        // Reset state
        #3;
        chk("rst_valid", exValid, 0);
        chk("rst_ready", idReady, 1);
        chk("rst_ctrl", exControl, 0);
        chk("rst_opa", exOperantA, 0);
        chk("rst_opb", exOperantB, 0);
        chk("rst_dest", exDest, 0);
        chk("rst_we", exWriteEn, 0);

        @(negedge clock);
        nReset = 1'b1;

        // Basic capture with immediate B
        idValid     = 1'b1;
        idControl   = 3'b001;
        idRegA      = 5'd1;
        idRegAData  = 32'hF0F0F0F0;
        idRegB      = 5'd2;
        idRegBData  = 32'h55555555;
        idUseImm    = 1'b1;
        idImmediate = 32'h0FF00000;
        idDest      = 5'd4;
        idWriteEn   = 1'b1;
        exReady     = 1'b1;
        #1;
        chk("cap1_ready", idReady, 1);
        step();
        chk("cap1_valid", exValid, 1);
        chk("cap1_ctrl", exControl, 3'b001);
        chk("cap1_opa", exOperantA, 32'hF0F0F0F0);
        chk("cap1_opb", exOperantB, 32'h0FF00000);
        chk("cap1_dest", exDest, 5'd4);
        chk("cap1_we", exWriteEn, 1);

        // Backpressure for three cycles, then same-cycle hand-off
        exReady     = 1'b0;
        idControl   = 3'b010;
        idRegA      = 5'd5;
        idRegAData  = 32'h11111111;
        idRegB      = 5'd6;
        idRegBData  = 32'h22222222;
        idUseImm    = 1'b0;
        idImmediate = 32'hDEAD0000;
        idDest      = 5'd8;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", idReady, 0);
            chk("bp_valid", exValid, 1);
            chk("bp_ctrl", exControl, 3'b001);
            chk("bp_opa", exOperantA, 32'hF0F0F0F0);
            chk("bp_opb", exOperantB, 32'h0FF00000);
            chk("bp_dest", exDest, 5'd4);
            step();
        end
        exReady = 1'b1;
        #1;
        chk("handoff_ready", idReady, 1);
        step();
        chk("handoff_valid", exValid, 1);
        chk("handoff_ctrl", exControl, 3'b010);
        chk("handoff_opa", exOperantA, 32'h11111111);
        chk("handoff_opb", exOperantB, 32'h22222222);
        chk("handoff_dest", exDest, 5'd8);

        // Drain
        idValid = 1'b0;
        step();
        chk("drain_valid", exValid, 0);

`ifdef OR1300_OPERAND_FORWARD_EN
        // Forwarding: mem wins over wb, value persists after both drop
        idValid    = 1'b1;
        idControl  = 3'b001;
        idRegA     = 5'd3;
        idRegAData = 32'h0BADF00D;
        idRegB     = 5'd0;
        idRegBData = 32'h33333333;
        idUseImm   = 1'b0;
        idDest     = 5'd3;
        exReady    = 1'b1;
        step();
        idValid    = 1'b0;
        exReady    = 1'b0;
        memWriteEn = 1'b1;
        memDest    = 5'd3;
        memData    = 32'h12345678;
        wbWriteEn  = 1'b1;
        wbDest     = 5'd3;
        wbData     = 32'hAAAAAAAA;
        #1;
        chk("fwd_mem_opa", exOperantA, 32'h12345678);
        chk("fwd_zero_opb", exOperantB, 32'h0);
        step();
        memWriteEn = 1'b0;
        wbWriteEn  = 1'b0;
        #1;
        chk("fwd_hold_opa", exOperantA, 32'h12345678);
        step();
        chk("fwd_hold2_opa", exOperantA, 32'h12345678);
        wbWriteEn = 1'b1;
        #1;
        chk("fwd_wb_opa", exOperantA, 32'hAAAAAAAA);
        wbWriteEn = 1'b0;
        exReady   = 1'b1;
        step();
        chk("fwd_drain_valid", exValid, 0);
`else
        // Stall on a pending wb write to a used source
        idValid     = 1'b1;
        idControl   = 3'b100;
        idRegA      = 5'd0;
        idRegAData  = 32'hDEADBEEF;
        idRegB      = 5'd7;
        idRegBData  = 32'h77777777;
        idUseImm    = 1'b0;
        idDest      = 5'd7;
        idWriteEn   = 1'b1;
        wbWriteEn   = 1'b1;
        wbDest      = 5'd7;
        wbData      = 32'h99999999;
        #1;
        chk("wb_stall_ready", idReady, 0);
        step();
        chk("wb_stall_valid", exValid, 0);
        chk("wb_stall_ready2", idReady, 0);
        wbWriteEn = 1'b0;
        #1;
        chk("wb_clear_ready", idReady, 1);
        step();
        chk("wb_cap_valid", exValid, 1);
        chk("wb_cap_opa_zero", exOperantA, 32'h0);
        chk("wb_cap_opb", exOperantB, 32'h77777777);
        chk("wb_cap_ctrl", exControl, 3'b100);
        // Held instruction writes r7: re-offer reading r7 must stall
        #1;
        chk("ex_stall_ready", idReady, 0);
        // Mem writer stall
        idRegA     = 5'd9;
        idRegB     = 5'd0;
        memWriteEn = 1'b1;
        memDest    = 5'd9;
        #1;
        chk("mem_stall_ready", idReady, 0);
        // Index 0 with matching dest 0 never stalls; immediate hides B
        idRegA      = 5'd0;
        memDest     = 5'd0;
        wbWriteEn   = 1'b1;
        wbDest      = 5'd0;
        idDest      = 5'd3;
        #1;
        chk("zero_nostall_ready", idReady, 1);
        idRegB      = 5'd7;
        idUseImm    = 1'b1;
        idImmediate = 32'h00001234;
        #1;
        chk("imm_nostall_ready", idReady, 1);
        step();
        chk("imm_cap_valid", exValid, 1);
        chk("imm_cap_opb", exOperantB, 32'h00001234);
        chk("imm_cap_opa", exOperantA, 32'h0);
        memWriteEn = 1'b0;
        wbWriteEn  = 1'b0;
        idValid    = 1'b0;
        step();
        chk("nf_drain_valid", exValid, 0);
`endif

        // Flush overrides a simultaneous capture
        idValid    = 1'b1;
        idControl  = 3'b011;
        idRegA     = 5'd1;
        idRegAData = 32'hA5A5A5A5;
        idRegB     = 5'd2;
        idRegBData = 32'h5A5A5A5A;
        idUseImm   = 1'b0;
        idDest     = 5'd5;
        idWriteEn  = 1'b1;
        exReady    = 1'b1;
        step();
        chk("pre_flush_valid", exValid, 1);
        chk("pre_flush_opb", exOperantB, 32'h5A5A5A5A);
        idRegA = 5'd10;
        idRegB = 5'd11;
        flush  = 1'b1;
        #1;
        chk("flush_ready", idReady, 1);
        step();
        chk("flush_valid", exValid, 0);
        flush   = 1'b0;
        idValid = 1'b0;
        step();
        chk("flush_drop_valid", exValid, 0);

        // Asynchronous reset while holding
        idValid     = 1'b1;
        idControl   = 3'b110;
        idRegA      = 5'd12;
        idRegAData  = 32'hCAFEBABE;
        idRegB      = 5'd13;
        idUseImm    = 1'b1;
        idImmediate = 32'h0000FFFF;
        idDest      = 5'd9;
        idWriteEn   = 1'b1;
        step();
        chk("pre_rst_valid", exValid, 1);
        chk("pre_rst_opa", exOperantA, 32'hCAFEBABE);
        exReady = 1'b0;
        idValid = 1'b0;
        #2;
        nReset = 1'b0;
        #1;
        chk("arst_valid", exValid, 0);
        chk("arst_ctrl", exControl, 0);
        chk("arst_opa", exOperantA, 0);
        chk("arst_opb", exOperantB, 0);
        chk("arst_dest", exDest, 0);
        chk("arst_we", exWriteEn, 0);
        chk("arst_ready", idReady, 1);
        @(negedge clock);
        nReset = 1'b1;
        step();
        chk("post_rst_valid", exValid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter: REG_ADDR_WIDTH, 5, register-index width.
REQ-002 clock  in  1  rising-edge clock.
REQ-003 nReset  in  1  reset, asynchronous, active-low.
REQ-004 idValid  in  1  decode offers an instruction.
REQ-005 idReady  out  1  stage accepts the offer this cycle.
REQ-006 idControl  in  3  logic/extend unit control code.
REQ-007 idRegA, idRegB  in  REG_ADDR_WIDTH  source register indices.
REQ-008 idRegAData, idRegBData  in  32  register-file read data.
REQ-009 idUseImm  in  1  operand B is the immediate; idImmediate  in  32  immediate value.
REQ-010 idDest  in  REG_ADDR_WIDTH, idWriteEn  in  1  destination register and its write enable.
REQ-011 flush  in  1  discard the held instruction.
REQ-012 memWriteEn  in  1, memDest  in  REG_ADDR_WIDTH, memData  in  32  result of the instruction one stage downstream.
REQ-013 wbWriteEn  in  1, wbDest  in  REG_ADDR_WIDTH, wbData  in  32  write-back result.
REQ-014 exValid  out  1, exReady  in  1  downstream handshake.
REQ-015 exControl  out  3, exOperantA  out  32, exOperantB  out  32  feed the logic unit.
REQ-016 exDest  out  REG_ADDR_WIDTH, exWriteEn  out  1  destination carried forward.

Function
REQ-017 Single-entry pipeline register; an accepted instruction (idValid & idReady at a rising edge) appears on the ex* outputs with exValid=1 the next cycle (latency 1).
REQ-018 idReady = (!exValid | exReady) & !hazard; the same-cycle hand-off (exValid & exReady & idValid) holds the new instruction with no bubble.
REQ-019 exValid & !exReady: all held fields are stable, except operands refreshed per REQ-022.
REQ-020 flush: exValid=0 next cycle; it overrides any simultaneous capture, and the offered instruction is dropped.
REQ-021 Register index 0 reads as 0x00000000 and is never forwarded; idUseImm=1 selects idImmediate for B and disables B hazard/forwarding.
REQ-022 Held operand resolution, per source: mem match (memWriteEn & memDest==src) > wb match > held value; exOperant outputs show the resolved value combinationally, and the held register is updated with it on each cycle exValid & !exReady.
REQ-023 hazard = 0 when forwarding is compiled in; otherwise hazard per REQ-030.
REQ-024 Capture stores idRegAData/idRegBData as the initial held values; REQ-022 corrects them from the first held cycle on.

Reset
REQ-025 nReset low: exValid=0, exControl=0, exOperantA/B=0, exDest=0, exWriteEn=0, held source indices=0, immediately and asynchronously.
REQ-026 Reset mid-transfer discards the held instruction; idReady=1 while in reset.
REQ-027 Release of reset is sampled synchronously; first capture is possible on the first rising edge after release.

Configuration
REQ-028 Macro OR1300_OPERAND_FORWARD_EN selects the hazard handling.
REQ-029 Defined: REQ-022 forwarding active; hazard=0.
REQ-030 Undefined: no forwarding (operands = held values); hazard=1 when a used nonzero idRegA/idRegB equals exDest (exValid & exWriteEn), memDest (memWriteEn) or wbDest (wbWriteEn).

Structure
REQ-031 Shared package or1300_pkg holds the control-code constants (AND=001, OR=010, XOR=011, PASS=000, SEXT16=100, SEXT8=101, ZEXT16=110, ZEXT8=111) and REG_ADDR_WIDTH.
REQ-032 Sub-module operand_forward, instantiated once per operand, implements the REQ-021/REQ-022 priority mux.

Verification
REQ-033 Accept idControl=001, regA data 0xF0F0F0F0, immediate 0x0FF00000, idUseImm=1, exReady=1 -> next cycle exValid=1, exOperantA=0xF0F0F0F0, exOperantB=0x0FF00000.
REQ-034 exReady=0 for 3 cycles with idValid=1 -> idReady=0, outputs stable; exReady=1 -> the held instruction leaves and the next one is captured in the same cycle.
REQ-035 (FORWARD_EN) held idRegA=3, memWriteEn=1, memDest=3, memData=0x12345678, with wb also matching with 0xAAAAAAAA -> exOperantA=0x12345678; after both drop, the value persists.
REQ-036 (no FORWARD_EN) idRegB=7 with wbWriteEn=1, wbDest=7 -> idReady=0 until wbWriteEn=0; idRegB=0 with a matching dest of 0 -> no stall.
REQ-037 flush and capture in the same cycle -> exValid=0 next cycle; nReset pulse while exValid=1 -> all outputs 0 with no clock edge.
